// File: rtl/mm_bus_initiator.sv
// Memory-mapped bus initiator: decodes PicoRV32 native requests onto NUM_PERIPH
// address windows and returns read data, an error pulse or a timeout abort.
module mm_bus_initiator #(
  parameter int          NUM_PERIPH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          SEL_LSB    = 8,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic                       bus_error,
  output logic [NUM_PERIPH-1:0]      per_select,
  output logic [31:0]                per_data_i,
  output logic [3:0]                 per_wstrb,
  output logic                       per_write_en,
  input  logic [NUM_PERIPH-1:0]      per_ready,
  input  logic [32*NUM_PERIPH-1:0]   per_data_o
);
  localparam int IDX_W   = $clog2(NUM_PERIPH);
  localparam int IW      = (IDX_W == 0) ? 1 : IDX_W;
  localparam int TAG_LSB = SEL_LSB + IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic                  r_ready, r_err, r_we;
  logic [31:0]           r_rdata, r_wdata;
  logic [3:0]            r_wstrb;
  logic [NUM_PERIPH-1:0] r_sel;

  logic [IW-1:0]         w_idx;
  logic                  w_mapped, w_hit;
  logic [31:0]           w_rd;
  logic [NUM_PERIPH-1:0] w_onehot;

  always_comb begin
    w_idx    = (IDX_W == 0) ? '0 : IW'(mem_addr >> SEL_LSB);
    w_mapped = ((mem_addr >> TAG_LSB) == (BASE_ADDR >> TAG_LSB)) &&
               ({{(32-IW){1'b0}}, w_idx} < 32'(NUM_PERIPH));
    w_onehot = NUM_PERIPH'(1) << w_idx;
  end

  // r_sel is one-hot, so masking ignores ready/data of unselected peripherals
  always_comb begin
    w_hit = |(per_ready & r_sel);
    w_rd  = '0;
    for (int i = 0; i < NUM_PERIPH; i++)
      if (r_sel[i]) w_rd = per_data_o[32*i +: 32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_sel   <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (mem_valid) begin
          if (w_mapped) begin
            r_state <= S_ACCESS;
            r_sel   <= w_onehot;
            r_we    <= |mem_wstrb;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_cnt   <= '0;
          end else begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= ERR_DATA;
          end
        end
        S_ACCESS: begin
          if (w_hit || r_cnt == 8'(TIMEOUT - 1)) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_err   <= !w_hit;
            r_rdata <= w_hit ? w_rd : ERR_DATA;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // One idle cycle after DONE keeps a stale ready out of the next ACCESS
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready    = r_ready;
  assign mem_rdata    = r_rdata;
  assign bus_error    = r_err;
  assign per_select   = r_sel;
  assign per_data_i   = r_wdata;
  assign per_wstrb    = r_wstrb;
  assign per_write_en = r_we;
endmodule
